polar_sc_decoder_seq: RTL and testbench

- Sequential successive-cancellation (SC) polar decoder for block length N.
- Generalised successor to the team's combinational recursive decoder:
  - one shared N/2-lane f/g processing element, time-multiplexed over the decode tree;
  - frozen mask supplied per codeword at run time;
  - valid/ready handshakes on input and output;
  - re-encoded codeword output for CRC/list stages downstream.
- Sits between the LLR demapper and the info-bit extractor.

---
 rtl/polar_sc_decoder_seq_pkg.sv | 33 +++
 rtl/polar_sc_decoder_seq_if.sv | 19 +
 rtl/polar_sc_decoder_seq_pe.sv | 27 ++
 rtl/polar_sc_decoder_seq.sv | 150 +++++++++++++++
 tb/tb_polar_sc_decoder_seq.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/polar_sc_decoder_seq_pkg.sv
// Shared types and arithmetic helpers for the sequential SC polar decoder.
// f/g work on sign-extended 32-bit values and wrap the result to the caller's width.
package polar_pkg;

  typedef enum logic [1:0] {IDLE, DECODE, DONE} state_e;

  localparam int MAX_W = 32;
  typedef logic signed [MAX_W-1:0] wide_t;

  function automatic int llr_bits(input int bits, input int n);
    return bits + $clog2(n);
  endfunction

  function automatic wide_t wrap_w(input wide_t v, input int w);
    wide_t t;
    t = v <<< (MAX_W - w);
    return t >>> (MAX_W - w);
  endfunction

  // min-sum: sign(a)*sign(b)*min(|a|,|b|); magnitudes held wide so |min| never overflows
  function automatic wide_t f_minsum(input wide_t a, input wide_t b, input int w);
    wide_t ma, mb, m;
    ma = a[MAX_W-1] ? -a : a;
    mb = b[MAX_W-1] ? -b : b;
    m  = (ma < mb) ? ma : mb;
    return wrap_w((a[MAX_W-1] ^ b[MAX_W-1]) ? -m : m, w);
  endfunction

  function automatic wide_t g_func(input wide_t a, input wide_t b, input logic beta, input int w);
    return wrap_w(beta ? (b - a) : (b + a), w);
  endfunction

endpackage

// File: rtl/polar_sc_decoder_seq_if.sv
// Handshake and data bundle between demapper, decoder and info-bit extractor.
interface polar_sc_decoder_seq_if #(
  parameter int BITS = 8,
  parameter int N    = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [N-1:0][BITS-1:0]   y;
  logic [N-1:0]             frozen;
  logic                     out_valid;
  logic                     out_ready;
  logic [N-1:0]             u;
  logic [N-1:0]             x;

  modport master (output in_valid, y, frozen, out_ready,
                  input  in_ready, out_valid, u, x);
  modport slave  (input  in_valid, y, frozen, out_ready,
                  output in_ready, out_valid, u, x);
endinterface

// File: rtl/polar_sc_decoder_seq_pe.sv
// Shared f/g processing element: NUM_LANES parallel lanes, lanes >= 'lanes' read as zero.
module polar_pe import polar_pkg::*; #(
  parameter int NUM_LANES = 2,
  parameter int VEC_W     = 10,
  parameter int LANE_W    = 2
) (
  input  logic                            op_g,
  input  logic [LANE_W-1:0]               lanes,
  input  logic [NUM_LANES-1:0][VEC_W-1:0] a,
  input  logic [NUM_LANES-1:0][VEC_W-1:0] b,
  input  logic [NUM_LANES-1:0]            beta,
  output logic [NUM_LANES-1:0][VEC_W-1:0] res
);

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    localparam logic [LANE_W-1:0] IDX = LANE_W'(j);
    wide_t aw, bw;
    always_comb begin
      aw = wide_t'($signed(a[j]));
      bw = wide_t'($signed(b[j]));
      res[j] = '0;
      if (IDX < lanes)
        res[j] = VEC_W'(op_g ? g_func(aw, bw, beta[j], VEC_W) : f_minsum(aw, bw, VEC_W));
    end
  end

endmodule

// File: rtl/polar_sc_decoder_seq.sv
// Sequential SC polar decoder: one f or g node per cycle, depth-first, left child first.
// LLR bank s and partial-sum bank s hold 2^s entries at flat offset 2^s-1.
module polar_sc_decoder_seq import polar_pkg::*; #(
  parameter int BITS     = 8,
  parameter int N        = 4,
  parameter int LLR_BITS = llr_bits(BITS, N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  polar_sc_decoder_seq_if.slave io
);

  localparam int NS     = $clog2(N);
  localparam int SW     = NS + 1;
  localparam int NL     = N / 2;
  localparam int LANE_W = NS;

  typedef logic [LLR_BITS-1:0] llr_t;

  state_e         state_q, state_d;
  logic [SW-1:0]  stg_q;
  logic           is_g_q;
  logic [NS-1:0]  leaf_q;
  logic [N-1:0]   frozen_q, u_q, x_q;
  llr_t           llr_q [2*N-1];
  logic [N-2:0]   psum_q;

  logic [NL-1:0][LLR_BITS-1:0] pe_a, pe_b, pe_res;
  logic [NL-1:0]               pe_beta;
  logic [LANE_W-1:0]           pe_lanes;

  logic           leaf_u, last_leaf, stop;
  logic [N-1:0]   cur, nxt;
  logic [SW-1:0]  up_lvl;

  // PE operands: parent bank s+1 split in halves, beta from the left sibling at stage s
  always_comb begin
    pe_a    = '0;
    pe_b    = '0;
    pe_beta = '0;
    for (int s = 0; s < NS; s++)
      if (stg_q == SW'(s))
        for (int j = 0; j < (1 << s); j++) begin
          pe_a[j]    = llr_q[(2 << s) - 1 + j];
          pe_b[j]    = llr_q[(2 << s) - 1 + (1 << s) + j];
          pe_beta[j] = psum_q[(1 << s) - 1 + j];
        end
  end

  assign pe_lanes = LANE_W'(1) << stg_q;

  polar_pe #(.NUM_LANES(NL), .VEC_W(LLR_BITS), .LANE_W(LANE_W)) u_pe (
    .op_g  (is_g_q),
    .lanes (pe_lanes),
    .a     (pe_a),
    .b     (pe_b),
    .beta  (pe_beta),
    .res   (pe_res)
  );

  // Leaf decision plus partial-sum climb: each set low bit of the leaf index means the
  // node just finished was a right child, so merge it with its stored left sibling.
  always_comb begin
    leaf_u = ~frozen_q[leaf_q] & pe_res[0][LLR_BITS-1];
    cur    = '0;
    cur[0] = leaf_u;
    nxt    = '0;
    up_lvl = SW'(NS);
    stop   = 1'b0;
    for (int s = 0; s < NS; s++) begin
      if (!stop) begin
        if (!leaf_q[s]) begin
          stop   = 1'b1;
          up_lvl = SW'(s);
        end else begin
          nxt = cur;
          for (int j = 0; j < (1 << s); j++) begin
            nxt[j]          = psum_q[(1 << s) - 1 + j] ^ cur[j];
            nxt[j + (1 << s)] = cur[j];
          end
          cur = nxt;
        end
      end
    end
  end

  assign last_leaf = &leaf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (io.in_valid) state_d = DECODE;
      DECODE:  if (stg_q == '0 && last_leaf) state_d = DONE;
      DONE:    if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q    <= '0;
      is_g_q   <= 1'b0;
      leaf_q   <= '0;
      frozen_q <= '0;
      u_q      <= '0;
      x_q      <= '0;
      psum_q   <= '0;
      for (int i = 0; i < 2*N-1; i++) llr_q[i] <= '0;
    end else if (state_q == IDLE) begin
      if (io.in_valid) begin
        stg_q    <= SW'(NS - 1);
        is_g_q   <= 1'b0;
        leaf_q   <= '0;
        frozen_q <= io.frozen;
        for (int j = 0; j < N; j++) llr_q[N - 1 + j] <= LLR_BITS'($signed(io.y[j]));
      end
    end else if (state_q == DECODE) begin
      for (int s = 0; s < NS; s++)
        if (stg_q == SW'(s))
          for (int j = 0; j < (1 << s); j++) llr_q[(1 << s) - 1 + j] <= pe_res[j];
      if (stg_q != '0) begin
        stg_q  <= stg_q - 1'b1;
        is_g_q <= 1'b0;
      end else begin
        u_q[leaf_q] <= leaf_u;
        for (int s = 0; s < NS; s++)
          if (up_lvl == SW'(s))
            for (int j = 0; j < (1 << s); j++) psum_q[(1 << s) - 1 + j] <= cur[j];
        if (last_leaf) begin
          x_q <= cur;
        end else begin
          stg_q  <= up_lvl;
          is_g_q <= 1'b1;
          leaf_q <= leaf_q + 1'b1;
        end
      end
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.u         = u_q;
  assign io.x         = x_q;

endmodule

// File: tb/tb_polar_sc_decoder_seq.sv
// Directed and random checks of the sequential SC polar decoder at N=4 and N=8.
module tb_polar_sc_decoder_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  polar_sc_decoder_seq_if #(.BITS(8), .N(4)) a4 ();
  polar_sc_decoder_seq_if #(.BITS(8), .N(8)) a8 ();

  polar_sc_decoder_seq #(.BITS(8), .N(4)) dut4 (.clk(clk), .rst_n(rst_n), .io(a4));
  polar_sc_decoder_seq #(.BITS(8), .N(8)) dut8 (.clk(clk), .rst_n(rst_n), .io(a8));

  int n_chk = 0;
  int n_err = 0;

  function automatic logic [3:0][7:0] pack4(input int v0, input int v1, input int v2, input int v3);
    logic [3:0][7:0] r;
    r[0] = 8'(v0); r[1] = 8'(v1); r[2] = 8'(v2); r[3] = 8'(v3);
    return r;
  endfunction

  // Called at a negedge with the decoder idle; returns at the first negedge showing out_valid.
  task automatic run4(input logic [3:0][7:0] yv, input logic [3:0] fz,
                      output logic [3:0] uo, output logic [3:0] xo, output int lat);
    a4.in_valid = 1'b1; a4.y = yv; a4.frozen = fz;
    @(negedge clk);
    a4.in_valid = 1'b0;
    lat = 1;
    while (!a4.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    uo = a4.u; xo = a4.x;
  endtask

  task automatic release4();
    a4.out_ready = 1'b1;
    @(negedge clk);
    a4.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a4.in_valid = 1'b0; a4.out_ready = 1'b0; a4.y = '0; a4.frozen = '0;
    a8.in_valid = 1'b0; a8.out_ready = 1'b0; a8.y = '0; a8.frozen = '0;
    repeat (3) @(negedge clk);
    n_chk++; if (a4.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", a4.in_ready); end
    n_chk++; if (a4.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", a4.out_valid); end
    n_chk++; if (a4.u !== 4'b0000) begin n_err++; $display("FAIL reset_u: got %b want 0000", a4.u); end
    n_chk++; if (a4.x !== 4'b0000) begin n_err++; $display("FAIL reset_x: got %b want 0000", a4.x); end
    n_chk++; if ({a8.in_ready, a8.out_valid} !== 2'b10) begin n_err++; $display("FAIL reset_n8_hs: got %b want 10", {a8.in_ready, a8.out_valid}); end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if ({a4.in_ready, a4.out_valid} !== 2'b10) begin n_err++; $display("FAIL reset_release_hs: got %b want 10", {a4.in_ready, a4.out_valid}); end
  endtask

  task automatic test_decode();
    logic [3:0] uo, xo; int lat;
    run4(pack4(20, 20, -20, -20), 4'b0000, uo, xo, lat);
    n_chk++; if (lat !== 7) begin n_err++; $display("FAIL dec1_latency: got %0d want 7", lat); end
    n_chk++; if (uo !== 4'b1010) begin n_err++; $display("FAIL dec1_u: got %b want 1010", uo); end
    n_chk++; if (xo !== 4'b1100) begin n_err++; $display("FAIL dec1_x: got %b want 1100", xo); end
    release4();
    n_chk++; if ({a4.in_ready, a4.out_valid} !== 2'b10) begin n_err++; $display("FAIL dec1_release_hs: got %b want 10", {a4.in_ready, a4.out_valid}); end
    run4(pack4(-10, -10, -10, -10), 4'b0111, uo, xo, lat);
    n_chk++; if (uo !== 4'b1000) begin n_err++; $display("FAIL dec2_u: got %b want 1000", uo); end
    n_chk++; if (xo !== 4'b1111) begin n_err++; $display("FAIL dec2_x: got %b want 1111", xo); end
    release4();
    run4(pack4(10, 10, 10, 10), 4'b0111, uo, xo, lat);
    n_chk++; if (uo !== 4'b0000) begin n_err++; $display("FAIL dec3_u: got %b want 0000", uo); end
    n_chk++; if (xo !== 4'b0000) begin n_err++; $display("FAIL dec3_x: got %b want 0000", xo); end
    release4();
  endtask

  task automatic test_extremes();
    logic [3:0] uo, xo; int lat;
    run4(pack4(-128, -128, -128, -128), 4'b0000, uo, xo, lat);
    n_chk++; if (uo !== 4'b1000) begin n_err++; $display("FAIL ext_neg_u: got %b want 1000", uo); end
    n_chk++; if (xo !== 4'b1111) begin n_err++; $display("FAIL ext_neg_x: got %b want 1111", xo); end
    release4();
    run4(pack4(127, 127, 127, 127), 4'b0000, uo, xo, lat);
    n_chk++; if (uo !== 4'b0000) begin n_err++; $display("FAIL ext_pos_u: got %b want 0000", uo); end
    n_chk++; if (xo !== 4'b0000) begin n_err++; $display("FAIL ext_pos_x: got %b want 0000", xo); end
    release4();
  endtask

  task automatic test_backpressure();
    logic [3:0] uo, xo; int lat;
    run4(pack4(20, 20, -20, -20), 4'b0000, uo, xo, lat);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        a4.in_valid = 1'b1; a4.y = pack4(-10, -10, -10, -10); a4.frozen = 4'b0111;
      end else begin
        a4.in_valid = 1'b0;
      end
      @(negedge clk);
      n_chk++;
      if ({a4.out_valid, a4.in_ready, a4.u, a4.x} !== {1'b1, 1'b0, 4'b1010, 4'b1100}) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d: got ov=%b ir=%b u=%b x=%b want ov=1 ir=0 u=1010 x=1100",
                 c, a4.out_valid, a4.in_ready, a4.u, a4.x);
      end
    end
    a4.in_valid = 1'b0;
    release4();
    n_chk++; if ({a4.in_ready, a4.out_valid} !== 2'b10) begin n_err++; $display("FAIL bp_release_hs: got %b want 10", {a4.in_ready, a4.out_valid}); end
    repeat (10) @(negedge clk);
    n_chk++; if ({a4.in_ready, a4.out_valid} !== 2'b10) begin n_err++; $display("FAIL bp_no_ghost: got %b want 10", {a4.in_ready, a4.out_valid}); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] uo, xo; int lat;
    run4(pack4(20, -20, 20, 20), 4'b0000, uo, xo, lat);
    n_chk++; if ({uo, xo} !== {4'b0011, 4'b0010}) begin n_err++; $display("FAIL b2b_a: got u=%b x=%b want u=0011 x=0010", uo, xo); end
    release4();
    run4(pack4(-10, -10, -10, -10), 4'b0111, uo, xo, lat);
    n_chk++; if ({uo, xo} !== {4'b1000, 4'b1111}) begin n_err++; $display("FAIL b2b_b: got u=%b x=%b want u=1000 x=1111", uo, xo); end
    n_chk++; if (lat !== 7) begin n_err++; $display("FAIL b2b_b_latency: got %0d want 7", lat); end
    release4();
    run4(pack4(20, 20, -20, -20), 4'b0000, uo, xo, lat);
    n_chk++; if ({uo, xo} !== {4'b1010, 4'b1100}) begin n_err++; $display("FAIL b2b_c: got u=%b x=%b want u=1010 x=1100", uo, xo); end
    release4();
  endtask

  task automatic test_reset_mid();
    logic [3:0] uo, xo; int lat;
    a4.in_valid = 1'b1; a4.y = pack4(20, -20, 20, 20); a4.frozen = 4'b0000;
    @(negedge clk);
    a4.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++; if ({a4.in_ready, a4.out_valid} !== 2'b10) begin n_err++; $display("FAIL rmid_hs: got %b want 10", {a4.in_ready, a4.out_valid}); end
    n_chk++; if ({a4.u, a4.x} !== 8'h00) begin n_err++; $display("FAIL rmid_ux: got u=%b x=%b want 0000 0000", a4.u, a4.x); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if ({a4.in_ready, a4.out_valid} !== 2'b10) begin n_err++; $display("FAIL rmid_release_hs: got %b want 10", {a4.in_ready, a4.out_valid}); end
    run4(pack4(20, 20, -20, -20), 4'b0000, uo, xo, lat);
    n_chk++; if ({uo, xo} !== {4'b1010, 4'b1100}) begin n_err++; $display("FAIL rmid_next: got u=%b x=%b want u=1010 x=1100", uo, xo); end
    n_chk++; if (lat !== 7) begin n_err++; $display("FAIL rmid_latency: got %0d want 7", lat); end
    release4();
  endtask

  task automatic test_random8();
    logic [7:0] uref, fz, xref;
    logic [7:0][7:0] yv;
    int lat;
    for (int k = 0; k < 1000; k++) begin
      fz   = 8'($urandom);
      uref = 8'($urandom) & ~fz;
      xref = uref;
      for (int h = 1; h < 8; h = h * 2)
        for (int i = 0; i < 8; i++)
          if ((i & h) == 0) xref[i] = xref[i] ^ xref[i + h];
      for (int i = 0; i < 8; i++) yv[i] = xref[i] ? 8'(-50) : 8'(50);
      a8.in_valid = 1'b1; a8.y = yv; a8.frozen = fz;
      @(negedge clk);
      a8.in_valid = 1'b0;
      lat = 1;
      while (!a8.out_valid && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      n_chk++; if (lat !== 15) begin n_err++; $display("FAIL rnd8_latency #%0d: got %0d want 15", k, lat); end
      n_chk++; if ((a8.u & ~fz) !== uref) begin n_err++; $display("FAIL rnd8_u #%0d: got %b want %b (frozen %b)", k, a8.u, uref, fz); end
      n_chk++; if (a8.x !== xref) begin n_err++; $display("FAIL rnd8_x #%0d: got %b want %b", k, a8.x, xref); end
      a8.out_ready = 1'b1;
      @(negedge clk);
      a8.out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_extremes();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
